// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: opcode/stall inputs and datapath controls.
// master = controller, slave = datapath side.
interface fetch_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       hold;
  logic       pc_we;
  logic       ir_we;
  logic       branch;
  logic       jump;
  logic       ExtOp;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemWrite;
  logic [2:0] ALUOp;
  logic       illegal;
  logic [2:0] state;

  modport master (
    input  op, funct, hold,
    output pc_we, ir_we, branch, jump, ExtOp,
    output RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite,
    output ALUOp, illegal, state
  );

  modport slave (
    output op, funct, hold,
    input  pc_we, ir_we, branch, jump, ExtOp,
    input  RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite,
    input  ALUOp, illegal, state
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Multi-cycle Moore controller: fetch, decode, exec, mem, writeback.
// Decode works only on the opcode latched in S_FETCH.
module fetch_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [5:0] op_q;
  logic [5:0] funct_q;

  logic       is_r, is_lw, is_sw;
  logic       is_beq, is_j, is_ill;
  logic       alu_src, ext_op;
  logic [2:0] alu_op;
  logic       mem_last;

  always_comb begin
    is_r    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    is_ill  = 1'b0;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    alu_op  = ALU_ADD;
    unique case (1'b1)
      op_q == 6'h00 && funct_q == 6'h21: is_r = 1'b1;
      op_q == 6'h00 && funct_q == 6'h23: begin
        is_r   = 1'b1;
        alu_op = ALU_SUB;
      end
      op_q == 6'h00 && funct_q == 6'h25: begin
        is_r   = 1'b1;
        alu_op = ALU_OR;
      end
      op_q == 6'h00 && funct_q == 6'h2a: begin
        is_r   = 1'b1;
        alu_op = ALU_SLT;
      end
      op_q == 6'h09: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      op_q == 6'h0d: begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end
      op_q == 6'h0f: begin
        alu_src = 1'b1;
        alu_op  = ALU_LUI;
      end
      op_q == 6'h23: begin
        is_lw   = 1'b1;
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      op_q == 6'h2b: begin
        is_sw   = 1'b1;
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      op_q == 6'h04: begin
        is_beq = 1'b1;
        alu_op = ALU_SUB;
        ext_op = 1'b1;
      end
      op_q == 6'h02: is_j = 1'b1;
      default:       is_ill = 1'b1;
    endcase
  end

  assign mem_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      cnt     <= 4'd0;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else if (!bus.hold) begin
      case (state)
        S_FETCH: begin
          op_q    <= bus.op;
          funct_q <= bus.funct;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (is_j || is_ill) state <= S_FETCH;
          else                state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_beq) begin
            state <= S_FETCH;
          end else if (is_lw || is_sw) begin
            state <= S_MEM;
            cnt   <= 4'd0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_last) state <= is_sw ? S_FETCH : S_WB;
          else          cnt   <= cnt + 4'd1;
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  logic pc_we_d, ir_we_d, br_d, jp_d, ill_d;
  logic rw_d, mw_d, rd_d, m2r_d;
  logic src_d, ext_d;
  logic [2:0] aop_d;
  logic fire;

  always_comb begin
    pc_we_d = 1'b0;
    ir_we_d = 1'b0;
    br_d    = 1'b0;
    jp_d    = 1'b0;
    ill_d   = 1'b0;
    rw_d    = 1'b0;
    mw_d    = 1'b0;
    rd_d    = 1'b0;
    m2r_d   = 1'b0;
    src_d   = 1'b0;
    ext_d   = 1'b0;
    aop_d   = ALU_ADD;
    case (state)
      S_FETCH: ir_we_d = 1'b1;
      S_DECODE: begin
        if (is_j) begin
          jp_d    = 1'b1;
          pc_we_d = 1'b1;
        end else if (is_ill) begin
          ill_d   = 1'b1;
          pc_we_d = 1'b1;
        end
      end
      S_EXEC: begin
        src_d = alu_src;
        ext_d = ext_op;
        aop_d = alu_op;
        if (is_beq) begin
          br_d    = 1'b1;
          pc_we_d = 1'b1;
        end
      end
      S_MEM: begin
        src_d = alu_src;
        ext_d = ext_op;
        aop_d = alu_op;
        if (mem_last && is_sw) begin
          mw_d    = 1'b1;
          pc_we_d = 1'b1;
        end
      end
      S_WB: begin
        src_d   = alu_src;
        ext_d   = ext_op;
        aop_d   = alu_op;
        rw_d    = 1'b1;
        pc_we_d = 1'b1;
        rd_d    = is_r;
        m2r_d   = is_lw;
      end
      default: ;
    endcase
  end

  // Stall and reset suppress every write strobe in the same cycle.
  assign fire = reset & ~bus.hold;

  assign bus.pc_we    = pc_we_d & fire;
  assign bus.ir_we    = ir_we_d & fire;
  assign bus.branch   = br_d & fire;
  assign bus.jump     = jp_d & fire;
  assign bus.illegal  = ill_d & fire;
  assign bus.RegWrite = rw_d & fire;
  assign bus.MemWrite = mw_d & fire;
  assign bus.RegDst   = rd_d & reset;
  assign bus.MemtoReg = m2r_d & reset;
  assign bus.ALUSrc   = src_d & reset;
  assign bus.ExtOp    = ext_d & reset;
  assign bus.ALUOp    = aop_d & {3{reset}};
  assign bus.state    = state;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface -- parameters
REQ-001 SHALL provide MEM_LAT, default 1, data-memory access cycles spent in S_MEM (legal range 1..15).

Interface -- ports
REQ-002 SHALL provide clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide op  input  6  Inst[31:26] from instruction memory.
REQ-005 SHALL provide funct  input  6  Inst[5:0] from instruction memory.
REQ-006 SHALL provide hold  input  1  stall request; freezes the controller.
REQ-007 SHALL provide pc_we  output  1  PC register write enable, one pulse per retired instruction.
REQ-008 SHALL provide ir_we  output  1  instruction/opcode latch enable.
REQ-009 SHALL provide branch, jump, ExtOp  output  1 each  Fetch-datapath controls.
REQ-010 SHALL provide RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite  output  1 each  execute-datapath controls.
REQ-011 SHALL provide ALUOp  output  3  000 add, 001 sub, 010 or, 011 slt, 100 lui.
REQ-012 SHALL provide illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-013 SHALL provide state  output  3  current FSM state, for debug.

Function
REQ-014 SHALL implement Moore FSM states S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4; codes 5-7 SHALL go to S_FETCH next cycle with all enables low.
REQ-015 SHALL, in S_FETCH, assert ir_we, capture op/funct into internal registers, and go to S_DECODE; all later decode SHALL use the captured values only.
REQ-016 SHALL support op 000000 (funct 100001 addu, 100011 subu, 100101 or, 101010 slt), 001001 addiu, 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq and 000010 j; any other op/funct is illegal.
REQ-017 SHALL, in S_DECODE: j -> jump=1, pc_we=1, go to S_FETCH; illegal -> illegal=1, pc_we=1 (PC+4), go to S_FETCH; all others -> S_EXEC.
REQ-018 SHALL, in S_EXEC: beq -> branch=1, ALUOp=001, ExtOp=1, pc_we=1, go to S_FETCH; lw/sw -> ALUSrc=1, ALUOp=000, ExtOp=1, go to S_MEM; R-type/addiu/ori/lui -> go to S_WB.
REQ-019 SHALL, in S_MEM, count MEM_LAT cycles with a 4-bit counter cleared on entry; on the final cycle, sw asserts MemWrite=1 and pc_we=1 and goes to S_FETCH, while lw goes to S_WB.
REQ-020 SHALL, in S_WB, assert RegWrite=1 and pc_we=1 and go to S_FETCH; RegDst=1 only for R-type; MemtoReg=1 only for lw.
REQ-021 SHALL hold ALUSrc/ALUOp/ExtOp stable from S_EXEC through S_WB, with ALUSrc=1 for I-type, ExtOp=0 for ori/lui, and ALUOp per the funct/op mapping (addiu 000, ori 010, lui 100).
REQ-022 SHALL take latencies in cycles of: j 2, illegal 2, beq 3, R-type/I-ALU 4, sw 3+MEM_LAT, lw 4+MEM_LAT.
REQ-023 SHALL, while hold=1, keep state, counter and latched opcode unchanged and force pc_we, ir_we, RegWrite, MemWrite and illegal to 0; combinational controls stay driven; on release, resume in the same state/cycle.
REQ-024 SHALL assert at most one pc_we pulse per instruction; pc_we and ir_we SHALL never be high together.
REQ-025 SHALL drive branch and jump only in the cycle pc_we is high, so the PC mux selects them at that edge only.

Reset
REQ-026 SHALL, on reset low, immediately force state=S_FETCH, counter=0, latched op/funct=0 and all outputs to 0 except ir_we, which follows S_FETCH only after reset releases.
REQ-027 SHALL, on reset asserted mid-instruction, abort the instruction with no pc_we, RegWrite or MemWrite pulse, and SHALL fetch normally on the first edge after deassertion.

Verification
REQ-028 SHALL cover reset release then addu (op 0, funct 0x21) -> states 0,1,2,4; RegWrite=1, RegDst=1 and pc_we=1 in cycle 4 only.
REQ-029 SHALL cover lw with MEM_LAT=3 -> states 0,1,2,3,3,3,4; MemtoReg=1, RegWrite=1 and pc_we=1 in cycle 7; sw -> MemWrite=1 and pc_we=1 in cycle 6.
REQ-030 SHALL cover beq -> pc_we=1 and branch=1 in cycle 3; j -> pc_we=1 and jump=1 in cycle 2; neither asserted elsewhere.
REQ-031 SHALL cover op 0x3F -> illegal=1 and pc_we=1 in cycle 2, no RegWrite/MemWrite, next state S_FETCH.
REQ-032 SHALL cover hold=1 for 5 cycles inside S_MEM -> state and counter frozen, no enables; lw completes exactly 5 cycles late.
REQ-033 SHALL cover reset pulsed low during S_WB of ori -> RegWrite and pc_we never assert; state=0 asynchronously.
